mmio_timer: RTL

- Memory-mapped down-counting timer. It sits on the CPU memory bus (mem_cmd/mem_addr/write_data/read_data) beside the RAM, LED register and switch port.
- It is a bus responder: it decodes CPU MREAD/MWRITE commands to its address window and drives read_data through a tri-state only when selected.
- Software uses it for delays and for periodic LED blinking in demo programs.

---
 rtl/mmio_timer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_timer.sv
// mmio_timer - memory-mapped down-counting timer on the CPU memory bus.
//
// The timer responds to MREAD/MWRITE commands in a four-word window starting at
// BASE_ADDR. A prescaler divides clk, and every PRESCALE cycles the 16-bit
// COUNT register decrements. When COUNT goes from 1 to 0, the DONE flag sets.
// If AUTO is set, the timer then reloads COUNT from LOAD and keeps running;
// otherwise it stops.
//
// Register map (word offsets):
//   0 CTRL   (RW)  bit0 EN, bit1 AUTO, bit2 IE (only with MMIO_TIMER_IRQ_EN)
//   1 LOAD   (RW)  reload value
//   2 COUNT  (RO)  current count
//   3 STATUS (W1C) bit0 DONE
//
// Optional feature macro: MMIO_TIMER_IRQ_EN
//   Defined   -> CTRL.IE is implemented, and output irq = registered DONE & IE.
//   Undefined -> no irq port; CTRL bit2 reads 0 and ignores writes.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   mem_cmd     bus command: 2'b10 MREAD, 2'b01 MWRITE, otherwise none
//   mem_addr    bus word address
//   write_data  CPU write data
//   read_data   read data, driven only while this block is read-selected, else z
//   rd_en       high while this block drives read_data
//   done        mirror of STATUS.DONE
//   irq         (MMIO_TIMER_IRQ_EN only) interrupt request

module mmio_timer #(
    parameter logic [8:0] BASE_ADDR = 9'h180,
    parameter int         PRESCALE  = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        rd_en,
    output logic        done
`ifdef MMIO_TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic        done_q, done_d;
`ifdef MMIO_TIMER_IRQ_EN
    logic        ie_q, ie_d;
    logic        irq_q;
`endif

    logic        sel, sel_rd, sel_wr;
    logic [1:0]  off;
    logic        wr_ctrl, wr_load, wr_stat_clr;
    logic        tick, expire;
    logic [15:0] rdata;

    // Address decode
    assign sel    = (mem_addr[8:2] == BASE_ADDR[8:2]);
    assign off    = mem_addr[1:0];
    assign sel_rd = sel && (mem_cmd == 2'b10);
    assign sel_wr = sel && (mem_cmd == 2'b01);

    assign wr_ctrl     = sel_wr && (off == 2'd0);
    assign wr_load     = sel_wr && (off == 2'd1);
    assign wr_stat_clr = sel_wr && (off == 2'd3) && write_data[0];

    // Zero-latency read mux
    always_comb begin
        rdata = 16'h0000;
        case (off)
            2'd0: begin
                rdata[0] = en_q;
                rdata[1] = auto_q;
`ifdef MMIO_TIMER_IRQ_EN
                rdata[2] = ie_q;
`endif
            end
            2'd1: rdata = load_q;
            2'd2: rdata = count_q;
            default: rdata[0] = done_q;
        endcase
    end

    assign read_data = sel_rd ? rdata : 16'bz;
    assign rd_en     = sel_rd;
    assign done      = done_q;
`ifdef MMIO_TIMER_IRQ_EN
    assign irq       = irq_q;
`endif

    assign tick = (presc_q == PRESC_MAX);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        auto_d  = auto_q;
        load_d  = load_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = done_q;
`ifdef MMIO_TIMER_IRQ_EN
        ie_d    = ie_q;
`endif
        expire  = 1'b0;

        if (state_q == S_RUN) begin
            // A zero count on entry (LOAD was 0) expires at once instead of wrapping.
            if (count_q == 16'd0) begin
                expire = 1'b1;
            end else if (tick) begin
                presc_d = 16'd0;
                count_d = count_q - 16'd1;
                expire  = (count_q == 16'd1);
            end else begin
                presc_d = presc_q + 16'd1;
            end

            if (expire) begin
                presc_d = 16'd0;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    count_d = 16'd0;
                    en_d    = 1'b0;
                    state_d = S_EXPIRED;
                end
            end
        end

        if (wr_load) begin
            load_d = write_data;
        end

        // A CTRL write overrides any concurrent expiry for state, COUNT and EN.
        if (wr_ctrl) begin
            en_d   = write_data[0];
            auto_d = write_data[1];
`ifdef MMIO_TIMER_IRQ_EN
            ie_d   = write_data[2];
`endif
            if (write_data[0]) begin
                state_d = S_RUN;
                count_d = load_q;
                presc_d = 16'd0;
            end else begin
                state_d = S_IDLE;
                count_d = count_q;
                presc_d = presc_q;
            end
        end

        // Set has priority over a write-1-to-clear in the same cycle.
        if (wr_stat_clr) begin
            done_d = 1'b0;
        end
        if (expire) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            load_q  <= 16'd0;
            count_q <= 16'd0;
            presc_q <= 16'd0;
            done_q  <= 1'b0;
`ifdef MMIO_TIMER_IRQ_EN
            ie_q    <= 1'b0;
            irq_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            load_q  <= load_d;
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
`ifdef MMIO_TIMER_IRQ_EN
            ie_q    <= ie_d;
            irq_q   <= done_q & ie_q;
`endif
        end
    end

endmodule
